// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-outstanding memory port,
// with sub-word lane steering on stores and lane extraction/extension on loads.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no memory access in flight; picks a winner each cycle
// BUSY_IF | fetch access issued, waiting for mem_ack
// BUSY_DM | load/store access issued, waiting for mem_ack
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic [1:0]  dm_read,
    input  logic [1:0]  dm_write,
    input  logic        dm_se,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    state_t      state, state_nxt;
    logic [1:0]  dm_streak, dm_streak_nxt;
    logic [1:0]  op_size, op_size_nxt;
    logic [1:0]  op_lane, op_lane_nxt;
    logic        op_se, op_se_nxt;
    logic        op_store, op_store_nxt;

    logic        mem_req_nxt, mem_we_nxt;
    logic [3:0]  mem_be_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt;
    logic        if_ready_nxt, dm_ready_nxt, dm_err_nxt;
    logic [31:0] if_rdata_nxt, dm_rdata_nxt;

    logic        dm_pending, dm_store, dm_misaligned;
    logic [1:0]  dm_size;

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic se);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{se & b[7]}}, b};
            SZ_HALF: r = {{16{se & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // A simultaneous load and store request performs the store only.
    always_comb begin
        dm_store      = (dm_write != 2'b00);
        dm_pending    = dm_store || (dm_read != 2'b00);
        dm_size       = dm_store ? dm_write : dm_read;
        dm_misaligned = ((dm_size == SZ_HALF) && dm_addr[0]) ||
                        ((dm_size == SZ_WORD) && (dm_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_nxt     = state;
        dm_streak_nxt = dm_streak;
        op_size_nxt   = op_size;
        op_lane_nxt   = op_lane;
        op_se_nxt     = op_se;
        op_store_nxt  = op_store;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_be_nxt    = mem_be;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_ready_nxt  = 1'b0;
        dm_ready_nxt  = 1'b0;
        dm_err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                // The winner is picked from raw requests; a winner still showing its ready
                // pulse is not granted and the other port waits too this cycle.
                if (if_req && (!dm_pending || (dm_streak == 2'd3))) begin
                    if (!if_ready) begin
                        state_nxt     = BUSY_IF;
                        dm_streak_nxt = 2'd0;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = 1'b0;
                        mem_be_nxt    = 4'b1111;
                        mem_addr_nxt  = if_addr & 32'hFFFF_FFFC;
                        mem_wdata_nxt = 32'h0;
                    end
                end else if (dm_pending && !dm_ready) begin
                    dm_streak_nxt = if_req ? dm_streak + 2'd1 : 2'd0;
                    if (dm_misaligned) begin
                        // Misaligned accesses complete immediately without touching memory.
                        dm_ready_nxt = 1'b1;
                        dm_err_nxt   = 1'b1;
                        dm_rdata_nxt = 32'h0;
                    end else begin
                        state_nxt     = BUSY_DM;
                        op_size_nxt   = dm_size;
                        op_lane_nxt   = dm_addr[1:0];
                        op_se_nxt     = dm_se;
                        op_store_nxt  = dm_store;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = dm_store;
                        mem_addr_nxt  = {dm_addr[31:2], 2'b00};
                        mem_wdata_nxt = dm_store ? dm_wdata : 32'h0;
                        mem_be_nxt    = 4'b1111;
                        case (dm_size)
                            SZ_BYTE: begin
                                mem_be_nxt = 4'b0001 << dm_addr[1:0];
                                if (dm_store) mem_wdata_nxt = {4{dm_wdata[7:0]}};
                            end
                            SZ_HALF: begin
                                mem_be_nxt = dm_addr[1] ? 4'b1100 : 4'b0011;
                                if (dm_store) mem_wdata_nxt = {2{dm_wdata[15:0]}};
                            end
                            default: mem_be_nxt = 4'b1111;
                        endcase
                    end
                end
            end

            BUSY_IF: begin
                if (mem_ack) begin
                    state_nxt     = IDLE;
                    if_ready_nxt  = 1'b1;
                    if_rdata_nxt  = mem_rdata;
                    mem_req_nxt   = 1'b0;
                    mem_we_nxt    = 1'b0;
                    mem_be_nxt    = 4'b0000;
                    mem_addr_nxt  = 32'h0;
                    mem_wdata_nxt = 32'h0;
                end
            end

            BUSY_DM: begin
                if (mem_ack) begin
                    state_nxt     = IDLE;
                    dm_ready_nxt  = 1'b1;
                    dm_rdata_nxt  = op_store ? 32'h0
                                             : extract_load(mem_rdata, op_size, op_lane, op_se);
                    mem_req_nxt   = 1'b0;
                    mem_we_nxt    = 1'b0;
                    mem_be_nxt    = 4'b0000;
                    mem_addr_nxt  = 32'h0;
                    mem_wdata_nxt = 32'h0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dm_streak <= 2'd0;
            op_size   <= 2'd0;
            op_lane   <= 2'd0;
            op_se     <= 1'b0;
            op_store  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            dm_err    <= 1'b0;
            if_rdata  <= 32'h0;
            dm_rdata  <= 32'h0;
        end else begin
            state     <= state_nxt;
            dm_streak <= dm_streak_nxt;
            op_size   <= op_size_nxt;
            op_lane   <= op_lane_nxt;
            op_se     <= op_se_nxt;
            op_store  <= op_store_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_be    <= mem_be_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_ready  <= if_ready_nxt;
            dm_ready  <= dm_ready_nxt;
            dm_err    <= dm_err_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases, randomized single transactions
// and arbitration order, checked against arithmetic reference functions.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [1:0]  dm_read;
    logic [1:0]  dm_write;
    logic        dm_se;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_se    (dm_se),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .dm_err   (dm_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    always #5 clk = ~clk;

    // Reference model: size 1=byte, 2=half, 3=word.
    function automatic bit ref_misaligned(int size, logic [31:0] a);
        return (size == 2 && (a % 2) != 0) || (size == 3 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] ref_be(int size, logic [31:0] a);
        logic [31:0] v;
        if (size == 1)      v = 32'd1 << (a % 4);
        else if (size == 2) v = 32'd3 << (a & 32'd2);
        else                v = 32'd15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(int size, logic [31:0] d);
        if (size == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(int size, logic [31:0] a, logic [31:0] w, logic se);
        logic [31:0] v;
        int bits;
        if (size == 3) return w;
        bits = (size == 1) ? 8 : 16;
        v = (w >> (8 * (a % 4))) & ((32'd1 << bits) - 32'd1);
        if (se && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        dm_read = 2'b00; dm_write = 2'b00; dm_se = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
    endtask

    task automatic do_dm(input logic [1:0] rd, input logic [1:0] wr, input logic se,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mdata, input int delay, input string tag);
        int sz;
        bit st;
        logic [31:0] exp;
        st = (wr != 2'b00);
        sz = st ? int'(wr) : int'(rd);
        @(negedge clk);
        dm_read = rd; dm_write = wr; dm_se = se; dm_addr = addr; dm_wdata = wdata;
        @(negedge clk);
        if (ref_misaligned(sz, addr)) begin
            checks++;
            if (dm_ready !== 1'b1 || dm_err !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s misaligned: ready=%b err=%b rdata=%h mem_req=%b, expected 1 1 00000000 0",
                         tag, dm_ready, dm_err, dm_rdata, mem_req);
            end
        end else begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== st || mem_be !== ref_be(sz, addr) ||
                mem_addr !== (addr & 32'hFFFF_FFFC) || (st && mem_wdata !== ref_wdata(sz, wdata))) begin
                errors++;
                $display("FAIL %s issue: req=%b we=%b be=%b addr=%h wdata=%h, expected 1 %b %b %h %h",
                         tag, mem_req, mem_we, mem_be, mem_addr, mem_wdata, st, ref_be(sz, addr),
                         addr & 32'hFFFF_FFFC, ref_wdata(sz, wdata));
            end
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                checks++;
                if (mem_req !== 1'b1 || mem_be !== ref_be(sz, addr) || dm_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold: req=%b be=%b ready=%b, expected 1 %b 0",
                             tag, mem_req, mem_be, dm_ready, ref_be(sz, addr));
                end
            end
            mem_ack = 1'b1; mem_rdata = mdata;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
            exp = st ? 32'h0 : ref_load(sz, addr, mdata, se);
            checks++;
            if (dm_ready !== 1'b1 || dm_err !== 1'b0 || dm_rdata !== exp || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s complete: ready=%b err=%b rdata=%h mem_req=%b, expected 1 0 %h 0",
                         tag, dm_ready, dm_err, dm_rdata, mem_req, exp);
            end
        end
        dm_read = 2'b00; dm_write = 2'b00;
        @(negedge clk);
        checks++;
        if (dm_ready !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: ready=%b mem_req=%b, expected 0 0", tag, dm_ready, mem_req);
        end
    endtask

    task automatic do_if(input logic [31:0] addr, input logic [31:0] mdata, input int delay,
                         input string tag);
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== (addr & 32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL %s issue: req=%b we=%b be=%b addr=%h, expected 1 0 1111 %h",
                     tag, mem_req, mem_we, mem_be, mem_addr, addr & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || if_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: req=%b ready=%b, expected 1 0", tag, mem_req, if_ready);
            end
        end
        mem_ack = 1'b1; mem_rdata = mdata;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== mdata || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s complete: ready=%b rdata=%h mem_req=%b, expected 1 %h 0",
                     tag, if_ready, if_rdata, mem_req, mdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: ready=%b, expected 0", tag, if_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        if_req = 1'b1; dm_read = 2'b11; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ready, dm_ready, dm_err,
             if_rdata, dm_rdata} !== '0) begin
            errors++;
            $display("FAIL reset outputs: req=%b we=%b be=%b addr=%h wdata=%h ifr=%b dmr=%b err=%b ifd=%h dmd=%h, expected all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ready, dm_ready, dm_err,
                     if_rdata, dm_rdata);
        end
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_if(32'h100, 32'h0000_0013, 0, "fetch_0x100");
        do_dm(2'b01, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF_1234, 0, "lb_signed");
        do_dm(2'b01, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF_1234, 1, "lb_unsigned");
        do_dm(2'b00, 2'b10, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 0, "sh_0x202");
        do_dm(2'b11, 2'b00, 1'b0, 32'h301, 32'h0, 32'h0, 0, "lw_misaligned");
        do_dm(2'b10, 2'b01, 1'b0, 32'h405, 32'h1234_5678, 32'h0, 0, "store_over_load");
        do_dm(2'b10, 2'b00, 1'b1, 32'h402, 32'h0, 32'h8001_7FFF, 2, "lh_upper_signed");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] rd, wr;
            rd = 2'($urandom_range(0, 3));
            wr = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (rd == 2'b00 && wr == 2'b00) rd = 2'b11;
            if (n % 5 == 4)
                do_if($urandom, $urandom, $urandom_range(0, 3), "rand_fetch");
            else
                do_dm(rd, wr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), "rand_dm");
        end
    endtask

    task automatic test_idle_ack();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if_ready !== 1'b0 || dm_ready !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_ack: ifr=%b dmr=%b req=%b, expected 0 0 0", if_ready, dm_ready, mem_req);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        dm_read = 2'b11; dm_addr = 32'h500;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy issue: req=%b, expected 1", mem_req);
        end
        rst = 1'b1; dm_read = 2'b00;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        checks++;
        if (mem_req !== 1'b0 || dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy abandon: req=%b ready=%b, expected 0 0", mem_req, dm_ready);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_req !== 1'b0 || dm_ready !== 1'b0 || dm_rdata !== 32'h0) begin
                errors++;
                $display("FAIL rst_busy late_ack: req=%b ready=%b rdata=%h, expected 0 0 00000000",
                         mem_req, dm_ready, dm_rdata);
            end
            @(negedge clk);
        end
        do_if(32'h104, 32'hCAFE_0001, 0, "fetch_after_rst");
    endtask

    task automatic test_arbitration();
        typedef enum {G_IF, G_DM} grant_t;
        grant_t got[$];
        grant_t exp[$];
        int streak;
        int cycles;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        streak = 0;
        for (int i = 0; i < 10; i++) begin
            if (streak == 3) begin exp.push_back(G_IF); streak = 0; end
            else begin exp.push_back(G_DM); streak++; end
        end
        if_req = 1'b1; if_addr = 32'h100;
        dm_read = 2'b11; dm_addr = 32'h400;
        cycles = 0;
        while (got.size() < 10 && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (mem_req === 1'b1) got.push_back((mem_addr == 32'h100) ? G_IF : G_DM);
            mem_ack = mem_req;
            mem_rdata = $urandom;
            if (dm_ready === 1'b1) dm_addr = dm_addr + 32'd4;
        end
        checks++;
        if (got.size() != 10) begin
            errors++;
            $display("FAIL arb_timeout: grants=%0d, expected 10", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL arb_order[%0d]: got %s, expected %s", i, got[i].name(), exp[i].name());
            end
        end
        if_req = 1'b0; dm_read = 2'b00;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_idle_ack();
        test_reset_busy();
        test_arbitration();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
